// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N-channel arbitrated bus multiplexer:
// selection-mode encoding and the rotate-priority pick function.
package mux_arb_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  localparam int MAX_N  = 16;
  localparam int MAX_SW = 4;

  typedef struct packed {
    logic              found;
    logic [MAX_SW-1:0] grant;
  } rr_pick_t;

  // First valid channel at or after ptr, wrapping at n (not at a power of two).
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]  valid,
                                       input logic [MAX_SW-1:0] ptr,
                                       input int                n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = 0; k < MAX_N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !r.found && valid[idx[MAX_SW-1:0]]) begin
        r.found = 1'b1;
        r.grant = idx[MAX_SW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_n_rr.sv
// Purely combinational rotate-priority arbiter; the pointer register lives
// in the parent.
module rr_arbiter_n
  import mux_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  in_valid,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          found
);

  rr_pick_t w_pick;

  assign w_pick = rr_pick(MAX_N'(in_valid), MAX_SW'(ptr), N);
  assign grant  = SW'(w_pick.grant);
  assign found  = w_pick.found;

endmodule

// File: rtl/mux_arb_n.sv
// N-channel WIDTH-bit bus multiplexer with a single registered output stage,
// external-select or round-robin (with lock) grant, valid/ready on all sides.
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 4,
  localparam int SW    = $clog2(N)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic               lock,
  input  logic [N*WIDTH-1:0] Din,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   D_out,
  output logic [SW-1:0]      D_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int NP = 1 << SW;

  logic [WIDTH-1:0] r_dOut;
  logic [SW-1:0]    r_dChan;
  logic             r_outValid;
  logic [SW-1:0]    r_ptr;

  mode_e            w_mode;
  logic [NP-1:0]    w_validExt;
  logic             w_selFound;
  logic [SW-1:0]    w_rrGrant;
  logic             w_rrFound;
  logic [SW-1:0]    w_grant;
  logic             w_found;
  logic             w_canAccept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_dataSel;
  logic [SW-1:0]    w_ptrNext;

  assign w_mode = mode_e'(mode);

  // Padding to a power of two lets an out-of-range sel index safely; it never grants.
  assign w_validExt = NP'(in_valid);
  assign w_selFound = ({1'b0, sel} < (SW+1)'(N)) && w_validExt[sel];

  rr_arbiter_n #(.N(N)) u_rr (
    .in_valid (in_valid),
    .ptr      (r_ptr),
    .grant    (w_rrGrant),
    .found    (w_rrFound)
  );

  assign w_grant     = (w_mode == MODE_RR) ? w_rrGrant : sel;
  assign w_found     = (w_mode == MODE_RR) ? w_rrFound : w_selFound;
  assign w_canAccept = !r_outValid || out_ready;
  assign w_xfer      = Reset_n && w_canAccept && w_found;
  assign in_ready    = w_xfer ? (N'(1) << w_grant) : '0;

  always_comb begin
    w_dataSel = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SW'(i)) w_dataSel = Din[i*WIDTH +: WIDTH];
    end
  end

  // Wrap is explicit so non-power-of-two N never lets the pointer reach N.
  always_comb begin
    w_ptrNext = r_ptr;
    if (w_xfer && (w_mode == MODE_RR)) begin
      if (lock)                        w_ptrNext = w_grant;
      else if (w_grant == SW'(N - 1))  w_ptrNext = '0;
      else                             w_ptrNext = w_grant + SW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_dOut     <= '0;
      r_dChan    <= '0;
      r_outValid <= 1'b0;
      r_ptr      <= '0;
    end else begin
      r_ptr <= w_ptrNext;
      if (w_xfer) begin
        r_dOut     <= w_dataSel;
        r_dChan    <= w_grant;
        r_outValid <= 1'b1;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign D_out     = r_dOut;
  assign D_chan    = r_dChan;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n: an N=4 and an N=3 instance share stimulus
// and are checked against a queue-based reference model.
module tb_mux_arb_n;

  logic        Clk      = 1'b0;
  logic        Reset_n  = 1'b0;
  logic        mode     = 1'b0;
  logic        lock     = 1'b0;
  logic        outReady = 1'b0;
  logic [1:0]  sel      = '0;
  logic [3:0]  inValid  = '0;
  logic [63:0] din      = '0;

  logic [3:0]  inReady4;
  logic [15:0] dOut4;
  logic [1:0]  dChan4;
  logic        outValid4;
  logic [2:0]  inReady3;
  logic [15:0] dOut3;
  logic [1:0]  dChan3;
  logic        outValid3;

  typedef struct {
    logic [15:0] data;
    int          chan;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int   total = 0;
  int   bad   = 0;
  int   mPtr[2];
  bit   mOutValid[2];

  always #5 Clk = ~Clk;

  mux_arb_n #(.WIDTH(16), .N(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .mode(mode), .sel(sel), .lock(lock),
    .Din(din), .in_valid(inValid), .in_ready(inReady4),
    .D_out(dOut4), .D_chan(dChan4), .out_valid(outValid4), .out_ready(outReady)
  );

  mux_arb_n #(.WIDTH(16), .N(3)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .mode(mode), .sel(sel), .lock(lock),
    .Din(din[47:0]), .in_valid(inValid[2:0]), .in_ready(inReady3),
    .D_out(dOut3), .D_chan(dChan3), .out_valid(outValid3), .out_ready(outReady)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference grant straight from the selection rules: -1 means no grant.
  function automatic int pickGrant(input int n, input int ptr, input logic [3:0] v,
                                   input logic m, input logic [1:0] s);
    int c;
    if (!m) return ((int'(s) < n) && v[s]) ? int'(s) : -1;
    for (int k = 0; k < n; k++) begin
      c = (ptr + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic modelStep(input int inst, input int n, input logic [3:0] actReady,
                           input logic actOutValid);
    int   g;
    bit   canAccept;
    logic [3:0] expReady;
    exp_t e;
    g         = pickGrant(n, mPtr[inst], inValid, mode, sel);
    canAccept = !mOutValid[inst] || outReady;
    expReady  = (canAccept && g >= 0) ? 4'(1 << g) : 4'b0;
    checkOutput($sformatf("in_ready_n%0d", n), 32'(actReady), 32'(expReady));
    checkOutput($sformatf("out_valid_n%0d", n), 32'(actOutValid), 32'(mOutValid[inst]));
    if (canAccept && g >= 0) begin
      e.data = din[g*16 +: 16];
      e.chan = g;
      if (inst == 0) q4.push_back(e);
      else           q3.push_back(e);
      if (mode) mPtr[inst] = lock ? g : (g + 1) % n;
      mOutValid[inst] = 1'b1;
    end else if (outReady) begin
      mOutValid[inst] = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic l,
                               input logic [3:0] v, input logic [63:0] d, input logic r);
    mode = m; sel = s; lock = l; inValid = v; din = d; outReady = r;
    @(negedge Clk);
    modelStep(0, 4, inReady4, outValid4);
    modelStep(1, 3, {1'b0, inReady3}, outValid3);
    @(posedge Clk);
    #1;
  endtask

  task automatic compareWord(input int inst, input logic [15:0] d, input logic [1:0] c);
    exp_t e;
    if ((inst == 0 && q4.size() == 0) || (inst == 1 && q3.size() == 0)) begin
      total++;
      bad++;
      $display("[TB] FAIL word_n%0d actual=chan%0d/%0h required=no word", inst == 0 ? 4 : 3, c, d);
    end else begin
      e = (inst == 0) ? q4.pop_front() : q3.pop_front();
      checkOutput($sformatf("D_out_n%0d", inst == 0 ? 4 : 3), 32'(d), 32'(e.data));
      checkOutput($sformatf("D_chan_n%0d", inst == 0 ? 4 : 3), 32'(c), 32'(e.chan));
    end
  endtask

  // A word is checked at the cycle it is consumed, so held words are checked once.
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset_n) begin
        if (outValid4 && outReady) compareWord(0, dOut4, dChan4);
        if (outValid3 && outReady) compareWord(1, dOut3, dChan3);
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out_valid_n4"}, 32'(outValid4), 32'(0));
    checkOutput({tag, "_D_out_n4"},     32'(dOut4),     32'(0));
    checkOutput({tag, "_D_chan_n4"},    32'(dChan4),    32'(0));
    checkOutput({tag, "_in_ready_n4"},  32'(inReady4),  32'(0));
    checkOutput({tag, "_out_valid_n3"}, 32'(outValid3), 32'(0));
    checkOutput({tag, "_D_out_n3"},     32'(dOut3),     32'(0));
    checkOutput({tag, "_in_ready_n3"},  32'(inReady3),  32'(0));
  endtask

  initial begin
    logic [63:0] chanData;
    logic [63:0] rnd;
    mPtr[0] = 0; mPtr[1] = 0;
    mOutValid[0] = 1'b0; mOutValid[1] = 1'b0;
    chanData = {16'h000D, 16'h000C, 16'h000B, 16'h000A};

    inValid = 4'hF; outReady = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checkResetState("init");
    Reset_n = 1'b1;

    // External select, including the out-of-range sel on the N=3 instance.
    applyStimulus(1'b0, 2'd2, 1'b0, 4'b1111, chanData, 1'b1);
    applyStimulus(1'b0, 2'd2, 1'b0, 4'b1111, chanData, 1'b1);
    applyStimulus(1'b0, 2'd3, 1'b0, 4'b1111, chanData, 1'b1);
    applyStimulus(1'b0, 2'd3, 1'b0, 4'b1111, chanData, 1'b1);

    // Backpressure then release with no bubble.
    applyStimulus(1'b0, 2'd1, 1'b0, 4'b0010, 64'h0000_0000_1234_0000, 1'b1);
    repeat (3) applyStimulus(1'b0, 2'd2, 1'b0, 4'b1111, chanData, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b0, 4'b1111, chanData, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 4'b0000, chanData, 1'b1);

    // Round-robin fairness from pointer 0.
    repeat (6) applyStimulus(1'b1, 2'd0, 1'b0, 4'b1111, chanData, 1'b1);

    // Move N=4 pointer to 3, then lock and wrap.
    applyStimulus(1'b1, 2'd0, 1'b0, 4'b0100, chanData, 1'b1);
    repeat (2) applyStimulus(1'b1, 2'd0, 1'b1, 4'b1001, chanData, 1'b1);
    repeat (2) applyStimulus(1'b1, 2'd0, 1'b0, 4'b1001, chanData, 1'b1);

    for (int i = 0; i < 300; i++) begin
      rnd = {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 4'($urandom), rnd,
                    ($urandom_range(0, 3) != 0));
    end
    repeat (2) applyStimulus(1'b0, 2'd0, 1'b0, 4'b0000, chanData, 1'b1);

    // Asynchronous reset while a word is held under backpressure.
    applyStimulus(1'b0, 2'd1, 1'b0, 4'b0010, 64'h0000_0000_BEEF_0000, 1'b0);
    checkOutput("pre_reset_D_out_n4", 32'(dOut4), 32'h0000_BEEF);
    inValid = 4'hF; outReady = 1'b1;
    #2;
    Reset_n = 1'b0;
    #1;
    checkResetState("midreset");
    q4.delete(); q3.delete();
    mPtr[0] = 0; mPtr[1] = 0;
    mOutValid[0] = 1'b0; mOutValid[1] = 1'b0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 4'b0001, 64'h0000_0000_0000_5A5A, 1'b1);

    for (int i = 0; i < 100; i++) begin
      rnd = {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 4'($urandom), rnd,
                    ($urandom_range(0, 2) != 0));
    end
    repeat (3) applyStimulus(1'b0, 2'd0, 1'b0, 4'b0000, chanData, 1'b1);

    checkOutput("leftover_n4", 32'(q4.size()), 32'(0));
    checkOutput("leftover_n3", 32'(q3.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
